fetch_group_pcgen: RTL and testbench

- Clocked, parametrised fetch-group PC generator for the superscalar front end.
- Each cycle it issues one aligned group of LANES sequential PCs to instruction memory.
- It scans the returned words for the first unconditional control transfer and truncates the group after that lane.
- It registers the group (PCs, instructions, valid mask) toward decode and steers the next group base.
- Supports decode back-pressure (stall) and an execute-stage redirect (mispredict/exception).

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_xfer_scan.sv | 51 +++++
 rtl/fetch_group_pcgen.sv | 94 +++++++++
 tb/tb_fetch_group_pcgen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and immediate helper for the fetch-group PC generator.
package fetch_pkg;

    localparam logic [5:0]  OP_J        = 6'b000010;
    localparam logic [15:0] BEQZZ_HI    = 16'h1000;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} fsm_state_t;

    // Returned wide so any XLEN up to 64 can take its low slice.
    function automatic logic [63:0] sext16_x4(input logic [15:0] imm);
        return {{46{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_xfer_scan.sv
// Combinational scan of a fetch group for the first unconditional control transfer.
module fetch_xfer_scan
    import fetch_pkg::*;
#(
    parameter int LANES = 8,
    parameter int XLEN  = 32,
    parameter int LW    = $clog2(LANES)
) (
    input  logic [LANES-1:0][XLEN-1:0] lane_pc,
    input  logic [LANES-1:0][XLEN-1:0] lane_instr,
    output logic                       hit,
    output logic [LW-1:0]              hit_lane,
    output logic [XLEN-1:0]            target,
    output logic [LANES-1:0]           lane_mask
);

    logic [LANES-1:0]           match;
    logic [LANES-1:0][XLEN-1:0] lane_tgt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [XLEN-1:0] pc4;
        logic [63:0]     off;
        logic            is_br;
        logic            is_j;

        assign pc4         = lane_pc[i] + XLEN'(INSTR_BYTES);
        assign off         = sext16_x4(lane_instr[i][15:0]);
        assign is_br       = lane_instr[i][31:16] == BEQZZ_HI;
        assign is_j        = lane_instr[i][31:26] == OP_J;
        assign match[i]    = is_br | is_j;
        assign lane_tgt[i] = is_br ? pc4 + off[XLEN-1:0]
                                   : {pc4[XLEN-1:28], lane_instr[i][25:0], 2'b00};
    end

    // Walk from the top lane down so the lowest matching lane is the last writer.
    always_comb begin
        hit       = 1'b0;
        hit_lane  = '0;
        target    = '0;
        lane_mask = {LANES{1'b1}};
        for (int i = LANES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit       = 1'b1;
                hit_lane  = LW'(i);
                target    = lane_tgt[i];
                lane_mask = {LANES{1'b1}} >> (LANES - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fetch_group_pcgen.sv
// Issues one aligned group of sequential PCs per cycle, truncates at the first taken
// transfer and registers the group toward decode.
module fetch_group_pcgen
    import fetch_pkg::*;
#(
    parameter int              LANES    = 8,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              LW       = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic [LANES*XLEN-1:0]   imem_addr,
    input  logic [LANES*XLEN-1:0]   imem_rdata,
    output logic                    grp_valid,
    output logic [LANES*XLEN-1:0]   grp_pc,
    output logic [LANES*XLEN-1:0]   grp_instr,
    output logic [LANES-1:0]        grp_lane_valid,
    output logic                    grp_taken,
    output logic [LW-1:0]           grp_taken_lane,
    output logic [31:0]             grp_count
);

    fsm_state_t                 state;
    logic [XLEN-1:0]            base_pc;
    logic [XLEN-1:0]            next_base;
    logic [LANES-1:0][XLEN-1:0] lane_pc;
    logic                       hit;
    logic [LW-1:0]              hit_lane;
    logic [XLEN-1:0]            target;
    logic [LANES-1:0]           lane_mask;

    for (genvar i = 0; i < LANES; i++) begin : g_pc
        assign lane_pc[i] = base_pc + XLEN'(INSTR_BYTES * i);
    end

    assign imem_addr = lane_pc;
    assign next_base = hit ? target : base_pc + XLEN'(INSTR_BYTES * LANES);

    fetch_xfer_scan #(.LANES(LANES), .XLEN(XLEN), .LW(LW)) u_scan (
        .lane_pc    (lane_pc),
        .lane_instr (imem_rdata),
        .hit        (hit),
        .hit_lane   (hit_lane),
        .target     (target),
        .lane_mask  (lane_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= BOOT;
            base_pc        <= RESET_PC;
            grp_valid      <= 1'b0;
            grp_pc         <= '0;
            grp_instr      <= '0;
            grp_lane_valid <= '0;
            grp_taken      <= 1'b0;
            grp_taken_lane <= '0;
            grp_count      <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, HOLD: begin
                    if (redirect_valid) begin
                        // Flush wins over stall; PC/instr payload is left as-is.
                        state          <= RUN;
                        base_pc        <= redirect_pc;
                        grp_valid      <= 1'b0;
                        grp_lane_valid <= '0;
                        grp_taken      <= 1'b0;
                        grp_taken_lane <= '0;
                    end else if (stall) begin
                        state <= HOLD;
                    end else begin
                        state          <= RUN;
                        base_pc        <= next_base;
                        grp_valid      <= 1'b1;
                        grp_pc         <= lane_pc;
                        grp_instr      <= imem_rdata;
                        grp_lane_valid <= lane_mask;
                        grp_taken      <= hit;
                        grp_taken_lane <= hit_lane;
                        grp_count      <= grp_count + 32'd1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_group_pcgen.sv
// Directed bench for fetch_group_pcgen with a small behavioural instruction memory.
module tb_fetch_group_pcgen;

    localparam int LANES = 8;
    localparam int XLEN  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic [LANES*XLEN-1:0] imem_addr;
    logic [LANES*XLEN-1:0] imem_rdata;
    logic                  grp_valid;
    logic [LANES*XLEN-1:0] grp_pc;
    logic [LANES*XLEN-1:0] grp_instr;
    logic [LANES-1:0]      grp_lane_valid;
    logic                  grp_taken;
    logic [2:0]            grp_taken_lane;
    logic [31:0]           grp_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_40;
    logic [31:0] mem_5c;

    fetch_group_pcgen #(.LANES(LANES), .XLEN(XLEN), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .grp_valid      (grp_valid),
        .grp_pc         (grp_pc),
        .grp_instr      (grp_instr),
        .grp_lane_valid (grp_lane_valid),
        .grp_taken      (grp_taken),
        .grp_taken_lane (grp_taken_lane),
        .grp_count      (grp_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [31:0] a;
        imem_rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            a = imem_addr[i*XLEN +: XLEN];
            case (a)
                32'h0000_0028: imem_rdata[i*XLEN +: XLEN] = 32'h1000_0004;
                32'h0000_0040: imem_rdata[i*XLEN +: XLEN] = mem_40;
                32'h0000_005C: imem_rdata[i*XLEN +: XLEN] = mem_5c;
                default:       imem_rdata[i*XLEN +: XLEN] = NOP;
            endcase
        end
    end

    function automatic logic [31:0] lane(input logic [LANES*XLEN-1:0] bus, input int i);
        return bus[i*XLEN +: XLEN];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_40 = 32'h1000_FFFF;
        mem_5c = NOP;
        step(); step();
        chk("rst_valid", grp_valid, 0);
        chk("rst_count", grp_count, 0);
        chk("rst_mask",  grp_lane_valid, 0);
        chk("rst_pc",    grp_pc, 0);
        chk("rst_addr0", lane(imem_addr, 0), 32'h0);
        chk("rst_addr7", lane(imem_addr, 7), 32'h1C);

        rst = 1'b0;
        step();
        chk("boot_valid", grp_valid, 0);
        step();
        // Sequential group at 0x00
        chk("g1_valid", grp_valid, 1);
        for (int i = 0; i < LANES; i++) chk($sformatf("g1_pc%0d", i), lane(grp_pc, i), 4 * i);
        chk("g1_mask",  grp_lane_valid, 8'hFF);
        chk("g1_taken", grp_taken, 0);
        chk("g1_count", grp_count, 1);
        chk("g1_next",  lane(imem_addr, 0), 32'h20);

        step();
        // Forward BEQZZ in lane 2
        chk("g2_pc0",   lane(grp_pc, 0), 32'h20);
        chk("g2_mask",  grp_lane_valid, 8'h07);
        chk("g2_taken", grp_taken, 1);
        chk("g2_lane",  grp_taken_lane, 2);
        chk("g2_instr", lane(grp_instr, 2), 32'h1000_0004);
        chk("g2_count", grp_count, 2);
        chk("g2_next",  lane(imem_addr, 0), 32'h3C);

        step();
        // Self-loop at 0x40 sits in lane 1 of the 0x3C group
        chk("g3_pc0",  lane(grp_pc, 0), 32'h3C);
        chk("g3_mask", grp_lane_valid, 8'h03);
        chk("g3_lane", grp_taken_lane, 1);
        chk("g3_next", lane(imem_addr, 0), 32'h40);

        step();
        chk("g4_pc0",  lane(grp_pc, 0), 32'h40);
        chk("g4_mask", grp_lane_valid, 8'h01);
        chk("g4_lane", grp_taken_lane, 0);
        chk("g4_next", lane(imem_addr, 0), 32'h40);

        mem_40 = NOP;
        mem_5c = 32'h0810_0000;
        step();
        // J in lane 7 of the 0x40 group
        chk("g5_pc0",   lane(grp_pc, 0), 32'h40);
        chk("g5_mask",  grp_lane_valid, 8'hFF);
        chk("g5_taken", grp_taken, 1);
        chk("g5_lane",  grp_taken_lane, 7);
        chk("g5_count", grp_count, 5);
        chk("g5_next",  lane(imem_addr, 0), 32'h0040_0000);

        step();
        chk("g6_pc0",   lane(grp_pc, 0), 32'h0040_0000);
        chk("g6_taken", grp_taken, 0);
        chk("g6_count", grp_count, 6);

        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("st_valid", grp_valid, 1);
            chk("st_pc0",   lane(grp_pc, 0), 32'h0040_0000);
            chk("st_count", grp_count, 6);
            chk("st_addr",  lane(imem_addr, 0), 32'h0040_0020);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        chk("rd_valid", grp_valid, 0);
        chk("rd_mask",  grp_lane_valid, 0);
        chk("rd_count", grp_count, 6);
        redirect_valid = 1'b0;
        step();
        chk("rd_hold_valid", grp_valid, 0);
        chk("rd_addr", lane(imem_addr, 0), 32'h100);
        stall = 1'b0;
        step();
        chk("rd_g_valid", grp_valid, 1);
        chk("rd_g_pc0",   lane(grp_pc, 0), 32'h100);
        chk("rd_g_count", grp_count, 7);

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
        step();
        chk("wr_flush", grp_valid, 0);
        redirect_valid = 1'b0;
        step();
        chk("wr_pc0",   lane(grp_pc, 0), 32'hFFFF_FFF0);
        chk("wr_pc3",   lane(grp_pc, 3), 32'hFFFF_FFFC);
        chk("wr_pc4",   lane(grp_pc, 4), 32'h0);
        chk("wr_pc7",   lane(grp_pc, 7), 32'hC);
        chk("wr_mask",  grp_lane_valid, 8'hFF);
        chk("wr_count", grp_count, 8);
        chk("wr_next",  lane(imem_addr, 0), 32'h10);
        step();
        chk("wr2_pc0", lane(grp_pc, 0), 32'h10);

        rst = 1'b1;
        step();
        chk("mr_valid", grp_valid, 0);
        chk("mr_count", grp_count, 0);
        chk("mr_pc",    grp_pc, 0);
        chk("mr_instr", grp_instr, 0);
        chk("mr_taken", grp_taken, 0);
        chk("mr_addr",  lane(imem_addr, 0), 32'h0);
        rst = 1'b0;
        step(); step();
        chk("mr_g_valid", grp_valid, 1);
        chk("mr_g_pc0",   lane(grp_pc, 0), 32'h0);
        chk("mr_g_count", grp_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
